// File: rtl/pe_pkg.sv
// Shared types, defaults and the saturating adder for the weight-stationary PE family.
package pe_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ACC_W_DEF  = 32;
  // Internal add width; every legal ACC_W and product fits with headroom.
  localparam int unsigned SAT_W      = 64;

  typedef struct packed {
    logic [SAT_W-1:0] sum;
    logic             ovf;
  } sat_res_t;

  function automatic logic mac_stages_ok(input int unsigned stages);
    return (stages == 1) || (stages == 2);
  endfunction

  // Operands arrive sign-extended to SAT_W; the sum is exact, and w selects the result width
  // against which overflow is judged and clamping is applied.
  function automatic sat_res_t sat_add(input logic [SAT_W-1:0] a,
                                       input logic [SAT_W-1:0] b,
                                       input int unsigned      w,
                                       input logic             sat);
    logic signed [SAT_W:0] s;
    logic signed [SAT_W:0] hi;
    logic [SAT_W-1:0]      max_v;
    sat_res_t              r;
    s     = $signed({a[SAT_W-1], a}) + $signed({b[SAT_W-1], b});
    hi    = s >>> (w - 1);
    max_v = {SAT_W{1'b1}} >> (SAT_W - w + 1);
    r.ovf = !((hi == '0) || (hi == '1));
    if (r.ovf && sat) begin
      r.sum = s[SAT_W] ? ~max_v : max_v;
    end else begin
      r.sum = s[SAT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_mac.sv
// Multiply-accumulate datapath: activation extension, signed multiply, optional pipeline
// register, add with wrap or saturation, and a per-cycle overflow strobe.
module pe_mac
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ACC_W      = ACC_W_DEF,
  parameter int unsigned MAC_STAGES = 1,
  parameter int unsigned SATURATE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              act_signed_i,
  input  logic [DATA_W-1:0] act_i,
  input  logic              act_valid_i,
  input  logic [DATA_W-1:0] weight_i,
  input  logic [ACC_W-1:0]  psum_i,
  input  logic              psum_valid_i,
  output logic [ACC_W-1:0]  psum_o,
  output logic              psum_valid_o,
  output logic              ovf_o
);

  localparam int unsigned PROD_W = 2 * DATA_W + 1;

  if (!mac_stages_ok(MAC_STAGES) || ACC_W < 2 || ACC_W >= SAT_W || PROD_W >= SAT_W)
  begin : gen_param_err
    $error("pe_mac: illegal parameter combination");
  end

  logic signed [DATA_W:0]   act_ext;
  logic signed [DATA_W:0]   w_ext;
  logic signed [PROD_W-1:0] prod;

  always_comb begin
    act_ext = {act_signed_i & act_i[DATA_W-1], act_i};
    w_ext   = {weight_i[DATA_W-1], weight_i};
    prod    = act_valid_i ? (PROD_W'(act_ext) * PROD_W'(w_ext)) : '0;
  end

  logic [PROD_W-1:0] add_prod;
  logic [ACC_W-1:0]  add_psum;
  logic              add_valid;

  if (MAC_STAGES == 2) begin : gen_pipe
    logic [PROD_W-1:0] prod_q;
    logic [ACC_W-1:0]  psum_q;
    logic              valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prod_q  <= '0;
        psum_q  <= '0;
        valid_q <= 1'b0;
      end else if (en_i) begin
        prod_q  <= prod;
        psum_q  <= psum_i;
        valid_q <= psum_valid_i;
      end
    end

    assign add_prod  = prod_q;
    assign add_psum  = psum_q;
    assign add_valid = valid_q;
  end else begin : gen_direct
    assign add_prod  = prod;
    assign add_psum  = psum_i;
    assign add_valid = psum_valid_i;
  end

  // Both operands are widened before the add so that a narrow ACC_W still reports an
  // out-of-range product as overflow instead of silently truncating it.
  sat_res_t res;
  always_comb begin
    res = sat_add({{(SAT_W - PROD_W){add_prod[PROD_W-1]}}, add_prod},
                  {{(SAT_W - ACC_W){add_psum[ACC_W-1]}}, add_psum},
                  ACC_W, SATURATE != 0);
  end

  logic unused_sum_hi;
  assign unused_sum_hi = ^res.sum[SAT_W-1:ACC_W];

  logic [ACC_W-1:0] psum_q, psum_d;
  logic             psum_valid_q, psum_valid_d;

  always_comb begin
    psum_d       = psum_q;
    psum_valid_d = psum_valid_q;
    if (en_i) begin
      psum_d       = res.sum[ACC_W-1:0];
      psum_valid_d = add_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psum_q       <= '0;
      psum_valid_q <= 1'b0;
    end else begin
      psum_q       <= psum_d;
      psum_valid_q <= psum_valid_d;
    end
  end

  assign psum_o       = psum_q;
  assign psum_valid_o = psum_valid_q;
  assign ovf_o        = en_i & add_valid & res.ovf;

endmodule

// File: rtl/pe_ws_dbuf.sv
// Weight-stationary PE with double-buffered (shadow/active) weights, pass-through
// activation/weight/swap registers and sticky overflow and swap-error flags.
module pe_ws_dbuf
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ACC_W      = ACC_W_DEF,
  parameter int unsigned MAC_STAGES = 1,
  parameter int unsigned SATURATE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              act_signed_i,
  input  logic              clear_flags_i,
  input  logic [DATA_W-1:0] w_in_i,
  input  logic              w_in_valid_i,
  output logic [DATA_W-1:0] w_out_o,
  output logic              w_out_valid_o,
  input  logic              swap_in_i,
  output logic              swap_out_o,
  input  logic [DATA_W-1:0] act_in_i,
  input  logic              act_in_valid_i,
  output logic [DATA_W-1:0] act_out_o,
  output logic              act_out_valid_o,
  input  logic [ACC_W-1:0]  psum_in_i,
  input  logic              psum_in_valid_i,
  output logic [ACC_W-1:0]  psum_out_o,
  output logic              psum_out_valid_o,
  output logic              ovf_o,
  output logic              swap_err_o
);

  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic              shadow_full_q, shadow_full_d;
  logic [DATA_W-1:0] active_q, active_d;
  logic              w_out_valid_q, w_out_valid_d;
  logic              swap_out_q, swap_out_d;
  logic [DATA_W-1:0] act_out_q, act_out_d;
  logic              act_out_valid_q, act_out_valid_d;
  logic              ovf_q, ovf_d;
  logic              swap_err_q, swap_err_d;
  logic              mac_ovf;

  // The MAC sees active_q, i.e. the weight before any swap taking effect on this edge.
  pe_mac #(
    .DATA_W     (DATA_W),
    .ACC_W      (ACC_W),
    .MAC_STAGES (MAC_STAGES),
    .SATURATE   (SATURATE)
  ) u_mac (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en_i),
    .act_signed_i (act_signed_i),
    .act_i        (act_in_i),
    .act_valid_i  (act_in_valid_i),
    .weight_i     (active_q),
    .psum_i       (psum_in_i),
    .psum_valid_i (psum_in_valid_i),
    .psum_o       (psum_out_o),
    .psum_valid_o (psum_out_valid_o),
    .ovf_o        (mac_ovf)
  );

  always_comb begin
    shadow_d        = shadow_q;
    shadow_full_d   = shadow_full_q;
    active_d        = active_q;
    w_out_valid_d   = w_out_valid_q;
    swap_out_d      = swap_out_q;
    act_out_d       = act_out_q;
    act_out_valid_d = act_out_valid_q;
    ovf_d           = ovf_q;
    swap_err_d      = swap_err_q;
    if (en_i) begin
      w_out_valid_d   = w_in_valid_i;
      swap_out_d      = swap_in_i;
      act_out_d       = act_in_i;
      act_out_valid_d = act_in_valid_i;
      if (swap_in_i) begin
        if (shadow_full_q) begin
          active_d      = shadow_q;
          shadow_full_d = 1'b0;
        end else begin
          swap_err_d = 1'b1;
        end
      end
      // A same-edge load refills the shadow just vacated by the swap.
      if (w_in_valid_i) begin
        shadow_d      = w_in_i;
        shadow_full_d = 1'b1;
      end
      if (mac_ovf) begin
        ovf_d = 1'b1;
      end
    end
    if (clear_flags_i) begin
      ovf_d      = 1'b0;
      swap_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q        <= '0;
      shadow_full_q   <= 1'b0;
      active_q        <= '0;
      w_out_valid_q   <= 1'b0;
      swap_out_q      <= 1'b0;
      act_out_q       <= '0;
      act_out_valid_q <= 1'b0;
      ovf_q           <= 1'b0;
      swap_err_q      <= 1'b0;
    end else begin
      shadow_q        <= shadow_d;
      shadow_full_q   <= shadow_full_d;
      active_q        <= active_d;
      w_out_valid_q   <= w_out_valid_d;
      swap_out_q      <= swap_out_d;
      act_out_q       <= act_out_d;
      act_out_valid_q <= act_out_valid_d;
      ovf_q           <= ovf_d;
      swap_err_q      <= swap_err_d;
    end
  end

  assign w_out_o         = shadow_q;
  assign w_out_valid_o   = w_out_valid_q;
  assign swap_out_o      = swap_out_q;
  assign act_out_o       = act_out_q;
  assign act_out_valid_o = act_out_valid_q;
  assign ovf_o           = ovf_q;
  assign swap_err_o      = swap_err_q;

endmodule
